hilo_mult_unit: RTL

- Iterative multiply unit that owns the HI/LO register pair.
- Acts as the responder to the control unit's mult/mfhi/mflo/mthi/mtlo decode: it accepts operands on a start strobe and computes a 2*WIDTH-bit product with a shift-add loop, one bit per cycle. It writes the product into HI/LO and presents HI or LO to the writeback mux.
- Asserts busy while computing so the datapath can stall dependent mfhi/mflo.

---
 rtl/hilo_mult_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hilo_mult_unit.sv
// HI/LO register pair with a shift-add multiplier that retires one multiplier bit per cycle.
// Signed operands are reduced to magnitudes up front and the sign is reapplied in a final fix-up cycle.
module hilo_mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wd,
   input  logic             hilo_sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rd_data
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic [1:0]         state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     upper_sum;
   logic [2*WIDTH-1:0] product;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      // The most negative value negates to itself, which is the correct unsigned magnitude.
      a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
      b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
      upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
      product   = neg_q ? -acc_q : acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               count_d  = '0;
               state_d  = S_CALC;
            end else begin
               if (we_hi) hi_d = wd;
               if (we_lo) lo_d = wd;
            end
         end
         S_CALC: begin
            // The carry out of the upper-half add becomes the new MSB after the shift.
            if (mplier_q[0]) acc_d = {upper_sum, acc_q[WIDTH-1:1]};
            else             acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == LAST_STEP) state_d = S_FIX;
         end
         S_FIX: begin
            hi_d    = product[2*WIDTH-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy    = (state_q == S_CALC) || (state_q == S_FIX);
   assign done    = done_q;
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign rd_data = hilo_sel ? hi_q : lo_q;

endmodule
